// File: rtl/regfile_pkg.sv
// Shared register-file widths and the writeback request record.
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback request FIFO: two ordered write ports, one read port,
// occupancy tracked by a counter so full and empty never alias.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic                       push0,
  input  wb_req_t                    din0,
  input  logic                       push1,
  input  wb_req_t                    din1,
  input  logic                       pop,
  output wb_req_t                    head,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr_inc;

  // DEPTH is a power of two, so natural pointer overflow wraps DEPTH-1 back to 0.
  assign wptr_inc = wptr + PTR_W'(1);
  assign head     = mem[rptr];

  // Storage: port 1 always lands in the slot after port 0, preserving order.
  always_ff @(posedge clk) begin
    if (push0) mem[wptr] <= din0;
    if (push1) mem[wptr_inc] <= din1;
  end

  // Pointers and occupancy; reset empties the queue and discards its contents.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      wptr <= wptr + PTR_W'(push0) + PTR_W'(push1);
      rptr <= rptr + PTR_W'(pop);
      occ  <= occ + OCC_W'(push0) + OCC_W'(push1) - OCC_W'(pop);
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-side front end of the register file: accepts ALU and LSU writebacks,
// queues them, drains one per cycle onto the write port and tracks which
// registers still have a write in flight.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic                lsu_valid,
  output logic                lsu_ready,
  input  logic [ADDR_W-1:0]   lsu_rd,
  input  logic [DATA_W-1:0]   lsu_data,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic [ADDR_W-1:0]   nD,
  output logic [DATA_W-1:0]   D,
  output logic                RegWE,
  output logic [NUM_REGS-1:0] pending,
  output logic                wb_idle
);

  localparam int OCC_W  = $clog2(DEPTH+1);
  localparam int CNT_W  = $clog2(DEPTH+2);
  localparam int WIDE_W = CNT_W + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  free;
  logic              lsu_acc;
  logic              alu_acc;
  logic              push0;
  logic              push1;
  logic              pop;
  wb_req_t           first_req;
  wb_req_t           second_req;
  wb_req_t           head;
  logic [CNT_W-1:0]  cnt      [NUM_REGS];
  logic [WIDE_W-1:0] cnt_wide [NUM_REGS];
  logic              cnt_ovf;

  // Free space comes from registered occupancy only; a same-cycle pop is not credited.
  assign free      = OCC_W'(DEPTH) - occ;
  assign lsu_ready = (free >= OCC_W'(1));
  assign alu_ready = (free >= OCC_W'(2)) || ((free == OCC_W'(1)) && !lsu_valid);
  assign lsu_acc   = lsu_valid && lsu_ready;
  assign alu_acc   = alu_valid && alu_ready;
  assign pop       = (occ != '0);
  assign push0     = lsu_acc || alu_acc;
  assign push1     = lsu_acc && alu_acc;
  assign wb_idle   = (occ == '0) && !RegWE;

  // Order the accepted requests: LSU goes first whenever it is accepted.
  always_comb begin
    first_req       = '0;
    second_req      = '0;
    second_req.rd   = alu_rd;
    second_req.data = alu_data;
    if (lsu_acc) begin
      first_req.rd   = lsu_rd;
      first_req.data = lsu_data;
    end else begin
      first_req.rd   = alu_rd;
      first_req.data = alu_data;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .Reset (Reset),
    .push0 (push0),
    .din0  (first_req),
    .push1 (push1),
    .din1  (second_req),
    .pop   (pop),
    .head  (head),
    .occ   (occ)
  );

  // Write port register: present the FIFO head for one cycle, otherwise hold nD/D.
  always_ff @(posedge clk) begin
    if (Reset) begin
      RegWE <= 1'b0;
      nD    <= '0;
      D     <= '0;
    end else if (pop) begin
      RegWE <= 1'b1;
      nD    <= head.rd;
      D     <= head.data;
    end else begin
      RegWE <= 1'b0;
    end
  end

  // Next pending count per register: both enqueues and the retiring write apply together.
  always_comb begin
    cnt_ovf = 1'b0;
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_wide[r] = {1'b0, cnt[r]}
                  + WIDE_W'(lsu_acc && (lsu_rd == ADDR_W'(r)))
                  + WIDE_W'(alu_acc && (alu_rd == ADDR_W'(r)))
                  - WIDE_W'(RegWE && (nD == ADDR_W'(r)));
      if (cnt_wide[r] > WIDE_W'(CNT_MAX)) cnt_ovf = 1'b1;
    end
  end

  // Pending counters; the width covers a full queue plus the write on the port.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (Reset) cnt[r] <= '0;
      else       cnt[r] <= cnt_wide[r][CNT_W-1:0];
    end
  end

  // Counter overflow or underflow would mean the bookkeeping is broken.
  always_ff @(posedge clk) begin
    if (!Reset) assert (!cnt_ovf);
  end

  // A register is pending while its counter is non-zero.
  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REGS; r++) pending[r] = (cnt[r] != '0);
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Reset;
  logic        lsu_valid, alu_valid;
  logic        lsu_ready, alu_ready;
  logic [3:0]  lsu_rd, alu_rd;
  logic [15:0] lsu_data, alu_data;
  logic [3:0]  nD;
  logic [15:0] D;
  logic        RegWE;
  logic [15:0] pending;
  logic        wb_idle;

  int checks = 0;
  int errors = 0;

  // Reference model: requests waiting in the queue plus the write on the port.
  logic [19:0] model_q[$];
  logic        m_we   = 1'b0;
  logic [3:0]  m_rd   = 4'd0;
  logic [15:0] m_data = 16'd0;

  regfile_wb_queue #(.DEPTH(DEPTH), .DATA_W(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .nD        (nD),
    .D         (D),
    .RegWE     (RegWE),
    .pending   (pending),
    .wb_idle   (wb_idle)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [15:0] modelPending();
    logic [15:0] p = '0;
    foreach (model_q[i]) p[model_q[i][19:16]] = 1'b1;
    if (m_we) p[m_rd] = 1'b1;
    return p;
  endfunction

  // One clock cycle: drive at the negedge, check ready, step model at the posedge,
  // then check the registered outputs at the following negedge.
  task automatic applyStimulus(input logic rst,
                               input logic lv, input logic [3:0] lrd, input logic [15:0] ld,
                               input logic av, input logic [3:0] ard, input logic [15:0] ad,
                               output logic la, output logic aa);
    int   free;
    logic exp_lr, exp_ar;
    Reset = rst;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    #1;
    free   = DEPTH - model_q.size();
    exp_lr = (free >= 1);
    exp_ar = (free >= 2) || (free == 1 && !lv);
    if (!rst) begin
      checkOutput("lsu_ready", 32'(lsu_ready), 32'(exp_lr));
      checkOutput("alu_ready", 32'(alu_ready), 32'(exp_ar));
    end
    la = !rst && lv && exp_lr;
    aa = !rst && av && exp_ar;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      m_we = 1'b0; m_rd = '0; m_data = '0;
    end else begin
      if (model_q.size() > 0) begin
        {m_rd, m_data} = model_q.pop_front();
        m_we = 1'b1;
      end else begin
        m_we = 1'b0;
      end
      if (la) model_q.push_back({lrd, ld});
      if (aa) model_q.push_back({ard, ad});
    end
    @(negedge clk);
    checkOutput("RegWE", 32'(RegWE), 32'(m_we));
    checkOutput("nD", 32'(nD), 32'(m_rd));
    checkOutput("D", 32'(D), 32'(m_data));
    checkOutput("pending", 32'(pending), 32'(modelPending()));
    checkOutput("wb_idle", 32'(wb_idle), 32'(model_q.size() == 0 && !m_we));
  endtask

  task automatic idleCycles(input int n);
    logic la, aa;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, la, aa);
  endtask

  initial begin
    logic la, aa;
    logic lhold, ahold;
    logic [3:0]  lrd_h, ard_h;
    logic [15:0] ld_h, ad_h;
    logic        rst_r;
    logic [3:0]  next_rd;

    Reset = 1'b1;
    lsu_valid = 1'b0; alu_valid = 1'b0;
    lsu_rd = '0; alu_rd = '0; lsu_data = '0; alu_data = '0;
    @(negedge clk);

    // Reset held with both sources requesting.
    applyStimulus(1'b1, 1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd8, 16'hCAFE, la, aa);
    applyStimulus(1'b1, 1'b1, 4'd7, 16'hBEEF, 1'b1, 4'd8, 16'hCAFE, la, aa);
    checkOutput("rst_regwe", 32'(RegWE), 32'd0);
    checkOutput("rst_pending", 32'(pending), 32'd0);
    checkOutput("rst_idle", 32'(wb_idle), 32'd1);
    idleCycles(2);

    // Single ALU write.
    applyStimulus(1'b0, 1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234, la, aa);
    checkOutput("single_pend", 32'(pending), 32'h0008);
    idleCycles(1);
    checkOutput("single_we", 32'(RegWE), 32'd1);
    checkOutput("single_nd", 32'(nD), 32'd3);
    checkOutput("single_d", 32'(D), 32'h1234);
    idleCycles(1);
    checkOutput("single_idle", 32'(wb_idle), 32'd1);
    checkOutput("single_clr", 32'(pending), 32'd0);

    // Dual enqueue: LSU ahead of ALU.
    applyStimulus(1'b0, 1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd1, 16'h5555, la, aa);
    checkOutput("dual_pend", 32'(pending), 32'h0006);
    idleCycles(1);
    checkOutput("dual_first", 32'({nD, D}), 32'h2AAAA);
    idleCycles(1);
    checkOutput("dual_second", 32'({nD, D}), 32'h15555);
    idleCycles(1);

    // Same register from both sources.
    applyStimulus(1'b0, 1'b1, 4'd5, 16'h1111, 1'b1, 4'd5, 16'h2222, la, aa);
    idleCycles(1);
    checkOutput("same_first", 32'(D), 32'h1111);
    idleCycles(1);
    checkOutput("same_second", 32'(D), 32'h2222);
    checkOutput("same_pend", 32'(pending[5]), 32'd1);
    idleCycles(1);
    checkOutput("same_clr", 32'(pending[5]), 32'd0);

    // Backpressure: both sources valid for 4 cycles with distinct registers.
    next_rd = 4'd0; lhold = 1'b0; ahold = 1'b0;
    lrd_h = '0; ard_h = '0; ld_h = '0; ad_h = '0;
    for (int c = 0; c < 4; c++) begin
      if (!lhold) begin lrd_h = next_rd; ld_h = 16'(c * 16'h0101 + 16'h1000); next_rd++; lhold = 1'b1; end
      if (!ahold) begin ard_h = next_rd; ad_h = 16'(c * 16'h0101 + 16'h2000); next_rd++; ahold = 1'b1; end
      applyStimulus(1'b0, 1'b1, lrd_h, ld_h, 1'b1, ard_h, ad_h, la, aa);
      if (la) lhold = 1'b0;
      if (aa) ahold = 1'b0;
    end
    idleCycles(6);

    // Mid-reset with three entries queued.
    applyStimulus(1'b0, 1'b1, 4'd9, 16'h0909, 1'b1, 4'd10, 16'h0A0A, la, aa);
    applyStimulus(1'b0, 1'b1, 4'd11, 16'h0B0B, 1'b1, 4'd12, 16'h0C0C, la, aa);
    checkOutput("mid_queued", 32'(pending), 32'h1E00);
    applyStimulus(1'b1, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0, la, aa);
    checkOutput("mid_regwe", 32'(RegWE), 32'd0);
    checkOutput("mid_pending", 32'(pending), 32'd0);
    idleCycles(3);

    // Random traffic; sources hold their request until accepted.
    lhold = 1'b0; ahold = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (!lhold) begin
        lhold = ($urandom_range(0, 9) < 7);
        lrd_h = 4'($urandom); ld_h = 16'($urandom);
      end
      if (!ahold) begin
        ahold = ($urandom_range(0, 9) < 7);
        ard_h = 4'($urandom); ad_h = 16'($urandom);
      end
      rst_r = ($urandom_range(0, 99) == 0);
      applyStimulus(rst_r, lhold, lrd_h, ld_h, ahold, ard_h, ad_h, la, aa);
      if (la || rst_r) lhold = 1'b0;
      if (aa || rst_r) ahold = 1'b0;
    end
    idleCycles(6);
    checkOutput("final_idle", 32'(wb_idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
